// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The master (controlling FSM) drives start/a/b/bin; the slave (the
// subtractor) returns busy/done/diff/bout. When SERIAL_SUBTRACTOR_OVF_EN
// is defined the bundle also carries the two's-complement overflow flag ovf.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flop.
// Sequence: IDLE -> (start) SHIFT for WIDTH cycles -> DONE (one cycle) -> IDLE.
// diff/bout (and ovf) are loaded only on entry to DONE and hold otherwise.
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the ovf output
// (two's-complement overflow of the subtraction).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [1:0]       cell_s;      // {borrow_out, difference bit}
    logic             last_bit_s;

    // One-bit full subtractor: returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        logic d;
        logic bo;
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
        return {bo, d};
    endfunction

    // Operand registers shift right, so the current bit is always at position 0.
    assign cell_s     = full_sub(a_q[0], b_q[0], brw_q);
    assign last_bit_s = (cnt_q == CW'(WIDTH - 1));

    // Next-state and datapath control for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SHIFT;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.bin;
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Result bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
                sh_d  = {cell_s[0], sh_q[WIDTH-1:1]};
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                brw_d = cell_s[1];
                if (last_bit_s) begin
                    state_d = ST_DONE;
                    cnt_d   = {CW{1'b0}};
                    diff_d  = sh_d;
                    bout_d  = cell_s[1];
                    done_d  = 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    // On the last bit a_q[0]/b_q[0] hold the operand MSBs.
                    ovf_d   = (a_q[0] ^ b_q[0]) & (a_q[0] ^ cell_s[0]);
`endif
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    busy_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output flops with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sh_q    <= {WIDTH{1'b0}};
            diff_q  <= {WIDTH{1'b0}};
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases plus
// randomized traffic, compared every cycle against an arithmetic model.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0 = idle, 1..W = busy cycles, W+1 = done cycle.
    int         phase;
    logic [W:0] pend, res;
    logic       pend_ovf, res_ovf;

    // Model update: result is plain (W+1)-bit arithmetic, published when done starts.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= 0;
            res     <= '0;
            res_ovf <= 1'b0;
            pend    <= '0;
            pend_ovf <= 1'b0;
        end else if (phase == 0) begin
            if (bus.start) begin
                logic [W:0] r;
                r = {1'b0, bus.a} - {1'b0, bus.b} - {{W{1'b0}}, bus.bin};
                phase    <= 1;
                pend     <= r;
                pend_ovf <= (bus.a[W-1] ^ bus.b[W-1]) & (bus.a[W-1] ^ r[W-1]);
            end
        end else if (phase == W) begin
            phase   <= W + 1;
            res     <= pend;
            res_ovf <= pend_ovf;
        end else if (phase == W + 1) begin
            phase <= 0;
        end else begin
            phase <= phase + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic eb, ed, ok;
        eb = (phase >= 1) && (phase <= W);
        ed = (phase == W + 1);
        ok = (bus.busy === eb) && (bus.done === ed) &&
             (bus.diff === res[W-1:0]) && (bus.bout === res[W]);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ok = ok && (bus.ovf === res_ovf);
`endif
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cycle t=%0t busy=%b exp %b done=%b exp %b diff=%h exp %h bout=%b exp %b",
                     $time, bus.busy, eb, bus.done, ed, bus.diff, res[W-1:0], bus.bout, res[W]);
        end
    end

    task automatic check_lit(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Issue one operation; report edges-to-done, busy cycle count and diff seen just after accept.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          output int lat, output int nbusy, output int held);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
        lat   = 0;
        held  = int'(bus.diff);
        nbusy = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy) nbusy++;
        end
        if (!bus.done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout actual=no_done expected=done_within_40");
        end
    endtask

    initial begin
        int lat, nbusy, held;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        repeat (3) @(negedge clk);
        check_lit("reset_busy", int'(bus.busy), 0);
        check_lit("reset_done", int'(bus.done), 0);
        check_lit("reset_diff", int'(bus.diff), 0);
        check_lit("reset_bout", int'(bus.bout), 0);
        rst_n = 1'b1;

        // 1: 10 - 3
        run_op(8'd10, 8'd3, 1'b0, lat, nbusy, held);
        check_lit("t1_diff", int'(bus.diff), 7);
        check_lit("t1_bout", int'(bus.bout), 0);
        check_lit("t1_latency", lat, 8);
        check_lit("t1_busy_cycles", nbusy, 8);
        @(negedge clk);
        check_lit("t1_done_one_cycle", int'(bus.done), 0);

        // 2: 3 - 10
        run_op(8'd3, 8'd10, 1'b0, lat, nbusy, held);
        check_lit("t2_diff", int'(bus.diff), 249);
        check_lit("t2_bout", int'(bus.bout), 1);

        // 3: 0 - 0 - 1, then equal operands with prior result held
        run_op(8'd0, 8'd0, 1'b1, lat, nbusy, held);
        check_lit("t3a_diff", int'(bus.diff), 255);
        check_lit("t3a_bout", int'(bus.bout), 1);
        run_op(8'h55, 8'h55, 1'b0, lat, nbusy, held);
        check_lit("t3_held_diff", held, 255);
        check_lit("t3b_diff", int'(bus.diff), 0);
        check_lit("t3b_bout", int'(bus.bout), 0);

        // 4: start held high with changing operands through SHIFT and DONE
        @(negedge clk);
        bus.a = 8'd20; bus.b = 8'd5; bus.bin = 1'b1; bus.start = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!bus.done && lat < 40) begin
            bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        check_lit("t4_latency", lat, 8);
        check_lit("t4_diff", int'(bus.diff), 14);
        check_lit("t4_bout", int'(bus.bout), 0);
        bus.a = 8'd1; bus.b = 8'd2; bus.bin = 1'b0;
        @(negedge clk);
        check_lit("t4_ignored_in_done", int'(bus.busy), 0);
        bus.start = 1'b0;
        run_op(8'd7, 8'd2, 1'b0, lat, nbusy, held);
        check_lit("t4_next_diff", int'(bus.diff), 5);

        // 5: reset at bit 4, then fresh operation
        @(negedge clk);
        bus.a = 8'd50; bus.b = 8'd70; bus.bin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_lit("t5_rst_busy", int'(bus.busy), 0);
        check_lit("t5_rst_done", int'(bus.done), 0);
        check_lit("t5_rst_diff", int'(bus.diff), 0);
        check_lit("t5_rst_bout", int'(bus.bout), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_op(8'd200, 8'd100, 1'b0, lat, nbusy, held);
        check_lit("t5_diff", int'(bus.diff), 100);
        check_lit("t5_bout", int'(bus.bout), 0);

        // 6: signed overflow boundary
        run_op(8'h80, 8'h01, 1'b0, lat, nbusy, held);
        check_lit("t6a_diff", int'(bus.diff), 127);
        check_lit("t6a_bout", int'(bus.bout), 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check_lit("t6a_ovf", int'(bus.ovf), 1);
`endif
        run_op(8'h05, 8'h03, 1'b0, lat, nbusy, held);
        check_lit("t6b_diff", int'(bus.diff), 2);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check_lit("t6b_ovf", int'(bus.ovf), 0);
`endif

        // Random traffic: start held for a random span with changing operands
        for (int i = 0; i < 1000; i++) begin
            int span;
            span = int'($urandom_range(1, 12));
            for (int k = 0; k < span; k++) begin
                @(negedge clk);
                bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
                bus.start = 1'b1;
            end
            @(negedge clk);
            bus.start = 1'b0;
            repeat (int'($urandom_range(0, 11))) @(negedge clk);
        end
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
